// File: rtl/ex_muldiv_pkg.sv
// Shared constants and encodings for the RV32M multi-cycle execute unit.
// Extends the core's common defines with the multiply/divide op and FSM encodings.
package ex_muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic                rstEnable    = 1'b1;
    localparam logic                writeDisable = 1'b0;
    localparam logic [XLEN_DEF-1:0] ZERO         = {XLEN_DEF{1'b0}};

    typedef enum logic [2:0] {
        opMUL    = 3'd0,
        opMULH   = 3'd1,
        opMULHSU = 3'd2,
        opMULHU  = 3'd3,
        opDIV    = 3'd4,
        opDIVU   = 3'd5,
        opREM    = 3'd6,
        opREMU   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Divide-group ops share the restoring divider; everything else uses the multiplier.
    function automatic logic op_is_div(input op_t op);
        return (op == opDIV) || (op == opDIVU) || (op == opREM) || (op == opREMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative datapath: operand magnitudes, shift-add multiplier, restoring divider,
// iteration counter and final sign fixup. Sequencing comes from the parent FSM.
module ex_muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            start,
    input  logic            flush,
    input  op_t             op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic              signed_a_s;
    logic              signed_b_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;

    op_t               op_r;
    logic              a_neg_r;
    logic              b_neg_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   mcand_r;
    logic [2*XLEN-1:0] prod_r;
    logic [XLEN-1:0]   div_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   quo_r;

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   quo_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;

    // Operand signedness from the incoming op; MULHSU treats only rs1 as signed.
    always_comb begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
        case (op)
            opMULH, opDIV, opREM: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            opMULHSU: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b0;
            end
            default: begin
                signed_a_s = 1'b0;
                signed_b_s = 1'b0;
            end
        endcase
    end

    assign a_neg_s = signed_a_s & rs1[XLEN-1];
    assign b_neg_s = signed_b_s & rs2[XLEN-1];
    assign mag_a_s = a_neg_s ? ({XLEN{1'b0}} - rs1) : rs1;
    assign mag_b_s = b_neg_s ? ({XLEN{1'b0}} - rs2) : rs2;

    // One iteration's worth of shift-add and restoring-division steps.
    always_comb begin : step_blk
        logic [XLEN:0] sum_v;
        logic [XLEN:0] shl_v;
        logic [XLEN:0] trial_v;
        prod_s  = prod_r;
        rem_s   = rem_r;
        quo_s   = quo_r;
        sum_v   = {(XLEN+1){1'b0}};
        shl_v   = {(XLEN+1){1'b0}};
        trial_v = {(XLEN+1){1'b0}};
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            sum_v  = {1'b0, prod_s[2*XLEN-1:XLEN]} +
                     (prod_s[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
            prod_s = {sum_v, prod_s[XLEN-1:1]};
            shl_v   = {rem_s, quo_s[XLEN-1]};
            trial_v = shl_v - {1'b0, div_r};
            if (!trial_v[XLEN]) begin
                rem_s = trial_v[XLEN-1:0];
                quo_s = {quo_s[XLEN-2:0], 1'b1};
            end else begin
                rem_s = shl_v[XLEN-1:0];
                quo_s = {quo_s[XLEN-2:0], 1'b0};
            end
        end
    end

    // Operand capture on start, then iterate until the counter drains.
    always_ff @(posedge clk_in) begin
        if (rst_in == rstEnable) begin
            op_r    <= opMUL;
            a_neg_r <= 1'b0;
            b_neg_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            mcand_r <= {XLEN{1'b0}};
            prod_r  <= {(2*XLEN){1'b0}};
            div_r   <= {XLEN{1'b0}};
            rem_r   <= {XLEN{1'b0}};
            quo_r   <= {XLEN{1'b0}};
        end else if (flush) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (start) begin
            op_r    <= op;
            a_neg_r <= a_neg_s;
            b_neg_r <= b_neg_s;
            cnt_r   <= CNT_W'(STEPS);
            rem_r   <= {XLEN{1'b0}};
            if (op_is_div(op)) begin
                mcand_r <= {XLEN{1'b0}};
                prod_r  <= {(2*XLEN){1'b0}};
                div_r   <= mag_b_s;
                quo_r   <= mag_a_s;
            end else begin
                mcand_r <= mag_a_s;
                prod_r  <= {{XLEN{1'b0}}, mag_b_s};
                div_r   <= {XLEN{1'b0}};
                quo_r   <= {XLEN{1'b0}};
            end
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (op_is_div(op_r)) begin
                rem_r <= rem_s;
                quo_r <= quo_s;
            end else begin
                prod_r <= prod_s;
            end
        end
    end

    assign done = (cnt_r == CNT_W'(1));

    // Sign fixup on the final step's values; remainder follows the dividend's sign.
    always_comb begin
        prod_fix_s = (a_neg_r ^ b_neg_r) ? ({(2*XLEN){1'b0}} - prod_s) : prod_s;
        quo_fix_s  = (a_neg_r ^ b_neg_r) ? ({XLEN{1'b0}} - quo_s) : quo_s;
        rem_fix_s  = a_neg_r ? ({XLEN{1'b0}} - rem_s) : rem_s;
        case (op_r)
            opMUL:                     result = prod_fix_s[XLEN-1:0];
            opMULH, opMULHSU, opMULHU: result = prod_fix_s[2*XLEN-1:XLEN];
            opDIV, opDIVU:             result = quo_fix_s;
            opREM, opREMU:             result = rem_fix_s;
            default:                   result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide execute unit: handshake FSM, divide special cases and
// the held writeback registers around the iterative datapath.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int BITS_PER_CYCLE = 1,
    parameter int REGIDX_W       = 5
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                flush_in,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic [2:0]          op_in,
    input  logic                rdE_in,
    input  logic [REGIDX_W-1:0] rdIdx_in,
    input  logic [XLEN-1:0]     rs1Data_in,
    input  logic [XLEN-1:0]     rs2Data_in,
    output logic                stall_out,
    output logic                valid_out,
    input  logic                ready_in,
    output logic                rdE_out,
    output logic [REGIDX_W-1:0] rdIdx_out,
    output logic [XLEN-1:0]     rdData_out
);

    state_t              state_r;
    state_t              state_nxt_s;
    op_t                 op_s;
    logic                accept_s;
    logic                start_s;
    logic                div0_s;
    logic                ovf_s;
    logic                special_s;
    logic [XLEN-1:0]     special_res_s;
    logic                iter_done_s;
    logic [XLEN-1:0]     iter_result_s;

    logic                valid_r;
    logic                ready_r;
    logic                rdE_r;
    logic [REGIDX_W-1:0] rdIdx_r;
    logic [XLEN-1:0]     rdData_r;

    assign op_s     = op_t'(op_in);
    assign accept_s = (state_r == ST_IDLE) & valid_in & ~flush_in;
    assign div0_s   = (rs2Data_in == {XLEN{1'b0}});
    assign ovf_s    = (rs1Data_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2Data_in == {XLEN{1'b1}});
    assign start_s  = accept_s & ~special_s;

    // Divide cases resolved without iterating: divide by zero and signed overflow.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = {XLEN{1'b0}};
        case (op_s)
            opDIV, opDIVU: begin
                if (div0_s) begin
                    special_s     = 1'b1;
                    special_res_s = {XLEN{1'b1}};
                end else if ((op_s == opDIV) && ovf_s) begin
                    special_s     = 1'b1;
                    special_res_s = rs1Data_in;
                end else begin
                    special_s     = 1'b0;
                    special_res_s = {XLEN{1'b0}};
                end
            end
            opREM, opREMU: begin
                if (div0_s) begin
                    special_s     = 1'b1;
                    special_res_s = rs1Data_in;
                end else if ((op_s == opREM) && ovf_s) begin
                    special_s     = 1'b1;
                    special_res_s = {XLEN{1'b0}};
                end else begin
                    special_s     = 1'b0;
                    special_res_s = {XLEN{1'b0}};
                end
            end
            default: begin
                special_s     = 1'b0;
                special_res_s = {XLEN{1'b0}};
            end
        endcase
    end

    // Next-state logic; flush overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (flush_in) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = special_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (iter_done_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (ready_in) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register with handshake flags registered alongside it.
    always_ff @(posedge clk_in) begin
        if (rst_in == rstEnable) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s == ST_DONE);
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Writeback registers: tag captured at accept, data at special accept or final step.
    always_ff @(posedge clk_in) begin
        if (rst_in == rstEnable) begin
            rdE_r    <= writeDisable;
            rdIdx_r  <= {REGIDX_W{1'b0}};
            rdData_r <= XLEN'(ZERO);
        end else if (accept_s) begin
            rdE_r    <= rdE_in & (rdIdx_in != {REGIDX_W{1'b0}});
            rdIdx_r  <= rdIdx_in;
            rdData_r <= special_s ? special_res_s : {XLEN{1'b0}};
        end else if ((state_r == ST_CALC) && iter_done_s && !flush_in) begin
            rdData_r <= iter_result_s;
        end
    end

    ex_muldiv_iter #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_iter (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (start_s),
        .flush  (flush_in),
        .op     (op_s),
        .rs1    (rs1Data_in),
        .rs2    (rs2Data_in),
        .done   (iter_done_s),
        .result (iter_result_s)
    );

    assign stall_out  = (state_r != ST_IDLE);
    assign ready_out  = ready_r;
    assign valid_out  = valid_r;
    assign rdE_out    = rdE_r;
    assign rdIdx_out  = rdIdx_r;
    assign rdData_out = rdData_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: scoreboard of expected writebacks,
// latency, hold, flush and reset behaviour.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        flush_in;
    logic        valid_in;
    logic        ready_out;
    logic [2:0]  op_in;
    logic        rdE_in;
    logic [4:0]  rdIdx_in;
    logic [31:0] rs1Data_in;
    logic [31:0] rs2Data_in;
    logic        stall_out;
    logic        valid_out;
    logic        ready_in;
    logic        rdE_out;
    logic [4:0]  rdIdx_out;
    logic [31:0] rdData_out;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        rde;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .flush_in   (flush_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .op_in      (op_in),
        .rdE_in     (rdE_in),
        .rdIdx_in   (rdIdx_in),
        .rs1Data_in (rs1Data_in),
        .rs2Data_in (rs2Data_in),
        .stall_out  (stall_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .rdE_out    (rdE_out),
        .rdIdx_out  (rdIdx_out),
        .rdData_out (rdData_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                          input int lat, input int hold);
        exp_t e;
        int   k;
        bit   seen;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(ready_out), 32'd1);
        op_in = op; rs1Data_in = a; rs2Data_in = b; rdIdx_in = rd; rdE_in = 1'b1;
        valid_in = 1'b1;
        sbq.push_back('{res, rd, (rd != 5'd0), lat});
        @(posedge clk);
        #1 valid_in = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < lat + 10) begin
            @(negedge clk);
            k++;
            if (valid_out) begin
                seen = 1'b1;
            end else begin
                chk({tag, "_busy_ready"}, 32'(ready_out), 32'd0);
                chk({tag, "_busy_stall"}, 32'(stall_out), 32'd1);
            end
        end
        e = sbq.pop_front();
        chk({tag, "_latency"}, seen ? 32'(k) : 32'hFFFF_FFFF, 32'(e.lat));
        chk({tag, "_data"}, rdData_out, e.data);
        chk({tag, "_idx"}, 32'(rdIdx_out), 32'(e.idx));
        chk({tag, "_rde"}, 32'(rdE_out), 32'(e.rde));
        chk({tag, "_done_ready"}, 32'(ready_out), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(valid_out), 32'd1);
            chk({tag, "_hold_data"}, rdData_out, e.data);
            chk({tag, "_hold_idx"}, 32'(rdIdx_out), 32'(e.idx));
        end
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        chk({tag, "_handoff_valid"}, 32'(valid_out), 32'd0);
        chk({tag, "_handoff_ready"}, 32'(ready_out), 32'd1);
    endtask

    initial begin
        int vcount;
        rst_in = 1'b1; flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        op_in = 3'd0; rdE_in = 1'b0; rdIdx_in = 5'd0; rs1Data_in = 32'd0; rs2Data_in = 32'd0;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_rde", 32'(rdE_out), 32'd0);
        chk("rst_idx", 32'(rdIdx_out), 32'd0);
        chk("rst_data", rdData_out, 32'd0);

        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 0);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 33, 0);
        run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 33, 0);
        run_op("mulhu",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h7FFF_FFFF, 33, 0);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33, 10);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33, 0);
        run_op("divu",   3'd5, 32'hFFFF_FFFE, 32'd3,         5'd11, 32'h5555_5554, 33, 0);
        run_op("div0",   3'd4, 32'd5,          32'd0,         5'd12, 32'hFFFF_FFFF, 1, 0);
        run_op("remu0",  3'd7, 32'd5,          32'd0,         5'd13, 32'd5,         1, 0);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, 0);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 1, 0);

        // flush alongside valid_in in IDLE must not be accepted
        @(negedge clk);
        op_in = 3'd0; rs1Data_in = 32'd3; rs2Data_in = 32'd3; rdIdx_in = 5'd1;
        valid_in = 1'b1; flush_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; flush_in = 1'b0;
        chk("idleflush_stall", 32'(stall_out), 32'd0);
        chk("idleflush_ready", 32'(ready_out), 32'd1);

        // flush wins over ready_in while DONE
        op_in = 3'd4; rs1Data_in = 32'd5; rs2Data_in = 32'd0; rdIdx_in = 5'd2; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        chk("doneflush_pre_valid", 32'(valid_out), 32'd1);
        flush_in = 1'b1; ready_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0; ready_in = 1'b0;
        chk("doneflush_valid", 32'(valid_out), 32'd0);
        chk("doneflush_ready", 32'(ready_out), 32'd1);

        // flush in the middle of a DIVU
        op_in = 3'd5; rs1Data_in = 32'd100; rs2Data_in = 32'd7; rdIdx_in = 5'd3; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (10) @(negedge clk);
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        chk("flush_stall", 32'(stall_out), 32'd0);
        chk("flush_ready", 32'(ready_out), 32'd1);
        chk("flush_valid", 32'(valid_out), 32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out) vcount++;
        end
        chk("flush_no_result", 32'(vcount), 32'd0);

        // reset in the middle of a DIVU
        op_in = 3'd5; rs1Data_in = 32'd100; rs2Data_in = 32'd7; rdIdx_in = 5'd4; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (10) @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        chk("midrst_ready", 32'(ready_out), 32'd1);
        chk("midrst_stall", 32'(stall_out), 32'd0);
        chk("midrst_valid", 32'(valid_out), 32'd0);
        chk("midrst_rde", 32'(rdE_out), 32'd0);
        chk("midrst_idx", 32'(rdIdx_out), 32'd0);
        chk("midrst_data", rdData_out, 32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out) vcount++;
        end
        chk("midrst_no_result", 32'(vcount), 32'd0);

        run_op("rd0",  3'd0, 32'd6, 32'd7, 5'd0, 32'd42, 33, 0);
        run_op("divu2", 3'd5, 32'd100, 32'd7, 5'd31, 32'd14, 33, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
